fib_sequencer: RTL and testbench

FIB_SEQUENCER -- requirements
Module: fib_sequencer

---
 rtl/fib_pkg.sv | 20 ++
 rtl/tick_divider.sv | 28 ++
 rtl/fib_sequencer.sv | 150 +++++++++++++++
 tb/tb_fib_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci term sequencer.
package fib_pkg;

  typedef logic [1:0] fib_state_t;

  localparam fib_state_t ST_IDLE = 2'd0;
  localparam fib_state_t ST_WAIT = 2'd1;
  localparam fib_state_t ST_STEP = 2'd2;
  localparam fib_state_t ST_DONE = 2'd3;

  // Overflow policy; the fourth encoding (2'b11) behaves like MODE_WRAP.
  localparam logic [1:0] MODE_WRAP = 2'b00;
  localparam logic [1:0] MODE_SAT  = 2'b01;
  localparam logic [1:0] MODE_HALT = 2'b10;

  function automatic logic is_busy(input fib_state_t s);
    return (s == ST_WAIT) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running prescaler: tick is high while the count sits at TICK_DIV-1.
module tick_divider #(
  parameter int TICK_DIV = 30000000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fib_sequencer.sv
// Fibonacci term generator: fills a term buffer from two seeds, one term per
// prescaler tick, with a selectable overflow policy and a registered read port.
module fib_sequencer
  import fib_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 30000000,
  localparam int IW      = $clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load_a,
  input  logic             load_b,
  input  logic [WIDTH-1:0] seed,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [IW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] term,
  output logic [IW-1:0]    term_idx,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [1:0]       state_dbg
);

  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  fib_state_t       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic [IW-1:0]    term_idx_q, term_idx_d;
  logic             ovf_q, ovf_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] rd_data_q;

  logic             tick;
  logic             clr;
  logic             step_we;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] step_wdata;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .Clock (Clock),
    .Reset (Reset),
    .clr   (clr),
    .tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    prev_d     = prev_q;
    cur_d      = cur_q;
    term_d     = term_q;
    term_idx_d = term_idx_q;
    ovf_d      = ovf_q;
    mode_d     = mode_q;
    clr        = 1'b0;
    step_we    = 1'b0;
    sum        = {1'b0, cur_q} + {1'b0, prev_q};
    step_wdata = sum[WIDTH-1:0];
    if (sum[WIDTH] && (mode_q == MODE_SAT)) step_wdata = '1;

    // Seed loads override everything, including a start in the same cycle.
    if (load_a || load_b) begin
      state_d    = ST_IDLE;
      term_d     = seed;
      term_idx_d = load_b ? IW'(1) : IW'(0);
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d = ST_WAIT;
            clr     = 1'b1;
            idx_d   = IW'(2);
            prev_d  = mem[0];
            cur_d   = mem[1];
            ovf_d   = 1'b0;
            mode_d  = mode;
          end
        end
        ST_WAIT: begin
          if (tick) state_d = ST_STEP;
        end
        ST_STEP: begin
          if (sum[WIDTH] && (mode_q == MODE_HALT)) begin
            ovf_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            step_we    = 1'b1;
            term_d     = step_wdata;
            term_idx_d = idx_q;
            prev_d     = cur_q;
            cur_d      = step_wdata;
            idx_d      = idx_q + 1'b1;
            ovf_d      = ovf_q | sum[WIDTH];
            state_d    = (idx_q == LAST_IDX) ? ST_DONE : ST_WAIT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      prev_q     <= '0;
      cur_q      <= '0;
      term_q     <= '0;
      term_idx_q <= '0;
      ovf_q      <= 1'b0;
      mode_q     <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      prev_q     <= prev_d;
      cur_q      <= cur_d;
      term_q     <= term_d;
      term_idx_q <= term_idx_d;
      ovf_q      <= ovf_d;
      mode_q     <= mode_d;
      rd_data_q  <= mem[rd_idx];
    end
  end

  // Buffer is never reset so a reset mid-run keeps the terms already produced.
  always_ff @(posedge Clock) begin
    if (load_a) mem[0] <= seed;
    if (load_b) mem[1] <= seed;
    if (step_we && !Reset) mem[idx_q] <= step_wdata;
  end

  assign rd_data   = rd_data_q;
  assign term      = term_q;
  assign term_idx  = term_idx_q;
  assign busy      = is_busy(state_q);
  assign done      = (state_q == ST_DONE);
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fib_sequencer.sv
// Directed and randomized checks of fib_sequencer against a plain-arithmetic
// Fibonacci model, on 16-bit, 8-bit and slow-tick instances.
module tb_fib_sequencer;
  import fib_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        load_a, load_b, start;
  logic [15:0] seed;
  logic [1:0]  mode;
  logic [3:0]  rd_idx;

  logic [15:0] r16, term16;
  logic [3:0]  ti16;
  logic        busy16, done16, ovf16;
  logic [1:0]  st16;

  logic [7:0]  r8, term8;
  logic [3:0]  ti8;
  logic        busy8, done8, ovf8;
  logic [1:0]  st8;

  logic        l4a, l4b, start4;
  logic [15:0] seed4;
  logic [1:0]  mode4;
  logic [3:0]  rd4;
  logic [15:0] r4, term4;
  logic [3:0]  ti4;
  logic        busy4, done4, ovf4;
  logic [1:0]  st4;

  int vectors = 0;
  int miscompares = 0;

  // model state: index 0 is the 16-bit instance, index 1 the 8-bit one
  int m [2][16];
  int mt [2];
  int mti [2];
  int mov [2];

  always #5 Clock = ~Clock;

  fib_sequencer #(.WIDTH(16), .DEPTH(16), .TICK_DIV(1)) u16 (
    .Clock(Clock), .Reset(Reset), .load_a(load_a), .load_b(load_b), .seed(seed),
    .start(start), .mode(mode), .rd_idx(rd_idx), .rd_data(r16), .term(term16),
    .term_idx(ti16), .busy(busy16), .done(done16), .ovf(ovf16), .state_dbg(st16)
  );

  fib_sequencer #(.WIDTH(8), .DEPTH(16), .TICK_DIV(1)) u8 (
    .Clock(Clock), .Reset(Reset), .load_a(load_a), .load_b(load_b), .seed(seed[7:0]),
    .start(start), .mode(mode), .rd_idx(rd_idx), .rd_data(r8), .term(term8),
    .term_idx(ti8), .busy(busy8), .done(done8), .ovf(ovf8), .state_dbg(st8)
  );

  fib_sequencer #(.WIDTH(16), .DEPTH(16), .TICK_DIV(4)) u4 (
    .Clock(Clock), .Reset(Reset), .load_a(l4a), .load_b(l4b), .seed(seed4),
    .start(start4), .mode(mode4), .rd_idx(rd4), .rd_data(r4), .term(term4),
    .term_idx(ti4), .busy(busy4), .done(done4), .ovf(ovf4), .state_dbg(st4)
  );

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_load(input bit a, input bit b, input int v);
    for (int k = 0; k < 2; k++) begin
      int msk;
      msk = (k == 0) ? 32'hffff : 32'hff;
      if (a) begin m[k][0] = v & msk; mt[k] = v & msk; mti[k] = 0; end
      if (b) begin m[k][1] = v & msk; mt[k] = v & msk; mti[k] = 1; end
    end
  endtask

  // Fibonacci with the overflow policy applied, terms 2..upto
  task automatic model_run(input int md, input int upto);
    for (int k = 0; k < 2; k++) begin
      int mx, p, c, s;
      mx = (k == 0) ? 65535 : 255;
      p = m[k][0];
      c = m[k][1];
      mov[k] = 0;
      for (int i = 2; i <= upto; i++) begin
        s = p + c;
        if (s > mx) begin
          mov[k] = 1;
          if (md == 2) break;
          s = (md == 1) ? mx : s - (mx + 1);
        end
        m[k][i] = s;
        mt[k] = s;
        mti[k] = i;
        p = c;
        c = s;
      end
    end
  endtask

  task automatic load(input bit a, input bit b, input logic [15:0] v);
    load_a = a; load_b = b; seed = v;
    step();
    load_a = 0; load_b = 0;
    model_load(a, b, v);
  endtask

  task automatic run(input int md, input bit poke, output int steps);
    mode = 2'(md); start = 1;
    step();
    start = 0;
    steps = 0;
    for (int n = 0; n < 200; n++) begin
      if (!busy16 && !busy8) break;
      if (st16 == ST_STEP) steps++;
      if (poke && n == 5) begin start = 1; mode = MODE_HALT; end
      step();
      start = 0; mode = 2'(md);
    end
    chk("run_timeout", 32'(busy16 | busy8), 0);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_done16"}, 32'(done16), 1);
    chk({tag, "_ovf16"}, 32'(ovf16), mov[0]);
    chk({tag, "_term16"}, 32'(term16), mt[0]);
    chk({tag, "_tidx16"}, 32'(ti16), mti[0]);
    chk({tag, "_done8"}, 32'(done8), 1);
    chk({tag, "_ovf8"}, 32'(ovf8), mov[1]);
    chk({tag, "_term8"}, 32'(term8), mt[1]);
    chk({tag, "_tidx8"}, 32'(ti8), mti[1]);
  endtask

  task automatic check_buf(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      step();
      chk($sformatf("%s_buf16[%0d]", tag, i), 32'(r16), m[0][i]);
      chk($sformatf("%s_buf8[%0d]", tag, i), 32'(r8), m[1][i]);
    end
  endtask

  task automatic wait_idx4(input logic [3:0] want, output int cyc);
    cyc = 0;
    while (ti4 != want && cyc < 100) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    int steps, c;
    Reset = 1; load_a = 0; load_b = 0; start = 0; seed = 0; mode = 0; rd_idx = 0;
    l4a = 0; l4b = 0; start4 = 0; seed4 = 0; mode4 = 0; rd4 = 0;
    repeat (3) step();
    chk("rst_state16", 32'(st16), 32'(ST_IDLE));
    chk("rst_busy16", 32'(busy16), 0);
    chk("rst_done16", 32'(done16), 0);
    chk("rst_ovf16", 32'(ovf16), 0);
    chk("rst_term16", 32'(term16), 0);
    chk("rst_tidx16", 32'(ti16), 0);
    chk("rst_rd16", 32'(r16), 0);
    chk("rst_busy4", 32'(busy4), 0);
    Reset = 0;
    step();

    // seeds 1/1 through both strobes at once
    load(1, 1, 16'd1);
    chk("both_term", 32'(term16), 1);
    chk("both_tidx", 32'(ti16), 1);
    chk("both_busy", 32'(busy16), 0);

    // wrap run, with an ignored start halfway through
    run(0, 1, steps);
    model_run(0, 15);
    chk("wrap_steps", steps, 14);
    chk("wrap_term16_const", 32'(term16), 987);
    check_outputs("wrap");
    check_buf("wrap");
    rd_idx = 13; step(); chk("wrap_u8_b13", 32'(r8), 121);
    rd_idx = 14; step(); chk("wrap_u8_b14", 32'(r8), 98);
    chk("wrap_ovf8_const", 32'(ovf8), 1);

    run(1, 0, steps);
    model_run(1, 15);
    check_outputs("sat");
    check_buf("sat");
    rd_idx = 13; step(); chk("sat_u8_b13", 32'(r8), 255);
    rd_idx = 14; step(); chk("sat_u8_b14", 32'(r8), 255);

    run(2, 0, steps);
    model_run(2, 15);
    check_outputs("halt");
    chk("halt_term8_const", 32'(term8), 233);
    chk("halt_tidx8_const", 32'(ti8), 12);
    check_buf("halt");

    // start together with load_b: the load wins
    load_b = 1; start = 1; seed = 16'd5;
    step();
    load_b = 0; start = 0;
    model_load(0, 1, 5);
    chk("ldst_state", 32'(st16), 32'(ST_IDLE));
    chk("ldst_busy", 32'(busy16), 0);
    chk("ldst_done", 32'(done16), 0);
    chk("ldst_term", 32'(term16), 5);
    chk("ldst_tidx", 32'(ti16), 1);
    step();
    chk("ldst_still_idle", 32'(busy16), 0);

    for (int it = 0; it < 6; it++) begin
      int md;
      if ($urandom_range(0, 3) != 0) load(1, 0, 16'($urandom_range(0, 65535)));
      load(0, 1, 16'($urandom_range(0, 65535)));
      md = $urandom_range(0, 3);
      run(md, 0, steps);
      model_run(md, 15);
      check_outputs($sformatf("rnd%0d", it));
      check_buf($sformatf("rnd%0d", it));
    end

    // reset in the middle of a run keeps written terms
    load(1, 1, 16'd1);
    mode = 0; start = 1;
    step();
    start = 0;
    c = 0;
    while (ti16 != 4'd6 && c < 100) begin step(); c++; end
    chk("mid_reach6", 32'(ti16), 6);
    Reset = 1;
    step();
    chk("mid_state16", 32'(st16), 32'(ST_IDLE));
    chk("mid_busy16", 32'(busy16), 0);
    chk("mid_term16", 32'(term16), 0);
    chk("mid_tidx16", 32'(ti16), 0);
    chk("mid_rd16", 32'(r16), 0);
    chk("mid_busy8", 32'(busy8), 0);
    chk("mid_term8", 32'(term8), 0);
    Reset = 0;
    model_run(0, 6);
    check_buf("mid");

    // slow tick instance: seeds 2/3, one term every 4 cycles
    l4a = 1; seed4 = 16'd2; step(); l4a = 0;
    l4b = 1; seed4 = 16'd3; step(); l4b = 0;
    start4 = 1; step(); start4 = 0;
    wait_idx4(4'd2, c);
    chk("t4_term5", 32'(term4), 5);
    wait_idx4(4'd3, c);
    chk("t4_gap1", c, 4);
    chk("t4_term8", 32'(term4), 8);
    wait_idx4(4'd4, c);
    chk("t4_gap2", c, 4);
    chk("t4_term13", 32'(term4), 13);
    c = 0;
    while (!done4 && c < 100) begin step(); c++; end
    chk("t4_done", 32'(done4), 1);
    start4 = 1; step(); start4 = 0;
    wait_idx4(4'd2, c);
    wait_idx4(4'd3, c);
    chk("t4_regap", c, 4);
    l4a = 1; seed4 = 16'd7; step(); l4a = 0;
    chk("t4_ld_busy", 32'(busy4), 0);
    chk("t4_ld_state", 32'(st4), 32'(ST_IDLE));
    chk("t4_ld_done", 32'(done4), 0);
    chk("t4_ld_term", 32'(term4), 7);
    chk("t4_ld_tidx", 32'(ti4), 0);
    rd4 = 0; step();
    chk("t4_buf0", 32'(r4), 7);
    rd4 = 2; step();
    chk("t4_buf2", 32'(r4), 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
